// File: rtl/fpu.sv
// Single-precision add/sub/mul unit: add/sub results register after one edge, multiply after two.
// Subnormals are flushed to zero. Rounding is round-to-nearest-even, and NaN results are canonical.
module fpu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  opcode,
    output logic [31:0] out
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // n[26] is the leading one, n[25:3] the fraction, and n[2:0] the guard/round/sticky bits.
    function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] exp,
                                               input logic [26:0] n);
        logic              inc;
        logic [24:0]       m;
        logic signed [9:0] e;
        inc = n[2] & (n[1] | n[0] | n[3]);
        m   = {1'b0, n[26:3]} + {24'b0, inc};
        e   = exp;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e <= 10'sd0)
            return {sign, 31'b0};
        else if (e >= 10'sd255)
            return {sign, 8'hFF, 23'b0};
        else
            return {sign, e[7:0], m[22:0]};
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        cnt = 5'd27;
        for (int unsigned i = 0; i < 27; i++)
            if (v[i]) cnt = 5'(26 - i);
        return cnt;
    endfunction

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign a_nan  = (ea == 8'hFF) && (fa != '0);
    assign b_nan  = (eb == 8'hFF) && (fb != '0);
    assign a_inf  = (ea == 8'hFF) && (fa == '0);
    assign b_inf  = (eb == 8'hFF) && (fb == '0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // Add/sub datapath
    logic              sb_eff, swap, eff_sub, s_big;
    logic [7:0]        e_big, e_small, diff;
    logic [23:0]       m_big, m_small;
    logic [26:0]       ext_small, mask, al_small, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e_norm;
    logic [31:0]       add_result;

    always_comb begin
        sb_eff     = sb ^ (opcode == OP_SUB);
        swap       = {ea, fa} < {eb, fb};
        s_big      = swap ? sb_eff : sa;
        eff_sub    = sa != sb_eff;
        e_big      = swap ? eb : ea;
        e_small    = swap ? ea : eb;
        m_big      = swap ? {1'b1, fb} : {1'b1, fa};
        m_small    = swap ? {1'b1, fa} : {1'b1, fb};
        diff       = e_big - e_small;
        ext_small  = {m_small, 3'b000};
        mask       = (27'd1 << diff) - 27'd1;
        al_small   = (ext_small >> diff) | {26'b0, |(ext_small & mask)};
        sum        = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, al_small})
                             : ({1'b0, m_big, 3'b000} + {1'b0, al_small});
        lz         = lzc27(sum[26:0]);
        if (sum[27]) begin
            norm   = {sum[27:2], sum[1] | sum[0]};
            e_norm = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            norm   = sum[26:0] << lz;
            e_norm = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end

        add_result = '0;
        if (a_nan || b_nan)
            add_result = QNAN;
        else if (a_inf && b_inf)
            add_result = (sa != sb_eff) ? QNAN : {sa, 8'hFF, 23'b0};
        else if (a_inf)
            add_result = {sa, 8'hFF, 23'b0};
        else if (b_inf)
            add_result = {sb_eff, 8'hFF, 23'b0};
        else if (a_zero && b_zero)
            add_result = {sa & sb_eff, 31'b0};
        else if (a_zero)
            add_result = {sb_eff, eb, fb};
        else if (b_zero)
            add_result = a;
        else if (sum == '0)
            add_result = '0;
        else
            add_result = round_pack(s_big, e_norm, norm);
    end

    // Multiply, stage 1: special operands are resolved here so that stage 2 only has to round.
    logic              mul_sign, mul_special;
    logic [31:0]       mul_special_val;
    logic signed [9:0] mul_exp;
    logic [47:0]       mul_prod;

    always_comb begin
        mul_sign        = sa ^ sb;
        mul_exp         = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        mul_prod        = {1'b1, fa} * {1'b1, fb};
        mul_special     = 1'b1;
        mul_special_val = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            mul_special_val = QNAN;
        else if (a_inf || b_inf)
            mul_special_val = {mul_sign, 8'hFF, 23'b0};
        else if (a_zero || b_zero)
            mul_special_val = {mul_sign, 31'b0};
        else
            mul_special = 1'b0;
    end

    logic              m1_valid, m1_sign, m1_special;
    logic signed [9:0] m1_exp;
    logic [47:0]       m1_prod;
    logic [31:0]       m1_special_val;
    logic [31:0]       mul_result;

    always_comb begin
        if (m1_special)
            mul_result = m1_special_val;
        else if (m1_prod[47])
            mul_result = round_pack(m1_sign, m1_exp + 10'sd1,
                                    {m1_prod[47:24], m1_prod[23], m1_prod[22], |m1_prod[21:0]});
        else
            mul_result = round_pack(m1_sign, m1_exp,
                                    {m1_prod[46:23], m1_prod[22], m1_prod[21], |m1_prod[20:0]});
    end

    // A multiply completing on this edge takes priority over an add/sub issued on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out            <= '0;
            m1_valid       <= 1'b0;
            m1_sign        <= 1'b0;
            m1_special     <= 1'b0;
            m1_exp         <= '0;
            m1_prod        <= '0;
            m1_special_val <= '0;
        end else begin
            m1_valid       <= (opcode == OP_MUL);
            m1_sign        <= mul_sign;
            m1_special     <= mul_special;
            m1_exp         <= mul_exp;
            m1_prod        <= mul_prod;
            m1_special_val <= mul_special_val;
            if (m1_valid)
                out <= mul_result;
            else if (opcode == OP_ADD || opcode == OP_SUB)
                out <= add_result;
        end
    end

endmodule

// File: tb/tb_fpu.sv
// Directed testbench for fpu: hand-computed binary32 vectors covering latency, collisions and special cases.
module tb_fpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  opcode = 2'b11;
    logic [31:0] out;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, RSV = 2'b11;

    fpu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop);
        @(negedge clk);
        a = va;
        b = vb;
        opcode = vop;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out !== 32'h0000_0000) begin
            $display("FAIL reset_initial: got %h expected %h", out, 32'h0000_0000);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        drive(32'h3F800000, 32'h41200000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h41300000) begin
            $display("FAIL add_1_plus_10: got %h expected %h", out, 32'h41300000);
            failures++;
        end
        drive(32'h3F800000, 32'h41200000, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h41300000) begin
            $display("FAIL reserved_hold: got %h expected %h", out, 32'h41300000);
            failures++;
        end
        drive(32'h80000000, 32'h80000000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h80000000) begin
            $display("FAIL add_negzero: got %h expected %h", out, 32'h80000000);
            failures++;
        end
    endtask

    task automatic test_sub;
        drive(32'h3F800000, 32'h41200000, SUB);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'hC1100000) begin
            $display("FAIL sub_1_minus_10: got %h expected %h", out, 32'hC1100000);
            failures++;
        end
        drive(32'h40490FDB, 32'h40490FDB, SUB);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h00000000) begin
            $display("FAIL sub_x_minus_x: got %h expected %h", out, 32'h00000000);
            failures++;
        end
    endtask

    task automatic test_mul;
        drive(32'h3F800000, 32'h41200000, MUL);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h00000000) begin
            $display("FAIL mul_latency_early: got %h expected %h", out, 32'h00000000);
            failures++;
        end
        drive(32'h0, 32'h0, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h41200000) begin
            $display("FAIL mul_1_times_10: got %h expected %h", out, 32'h41200000);
            failures++;
        end
        drive(32'h3FC00000, 32'h40000000, MUL);
        drive(32'h0, 32'h0, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h40400000) begin
            $display("FAIL mul_1p5_times_2: got %h expected %h", out, 32'h40400000);
            failures++;
        end
        drive(32'h80000000, 32'h3F800000, MUL);
        drive(32'h0, 32'h0, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h80000000) begin
            $display("FAIL mul_negzero_sign: got %h expected %h", out, 32'h80000000);
            failures++;
        end
    endtask

    task automatic test_rounding;
        drive(32'h3F800000, 32'h33800000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h3F800000) begin
            $display("FAIL round_tie_even_down: got %h expected %h", out, 32'h3F800000);
            failures++;
        end
        drive(32'h3F800001, 32'h33800000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h3F800002) begin
            $display("FAIL round_tie_even_up: got %h expected %h", out, 32'h3F800002);
            failures++;
        end
    endtask

    task automatic test_specials;
        drive(32'h7F800000, 32'h7F800000, SUB);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h7FC00000) begin
            $display("FAIL inf_minus_inf: got %h expected %h", out, 32'h7FC00000);
            failures++;
        end
        drive(32'h7F800000, 32'h3F800000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h7F800000) begin
            $display("FAIL inf_plus_finite: got %h expected %h", out, 32'h7F800000);
            failures++;
        end
        drive(32'h7FA00000, 32'h3F800000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h7FC00000) begin
            $display("FAIL nan_operand: got %h expected %h", out, 32'h7FC00000);
            failures++;
        end
        drive(32'h7F7FFFFF, 32'h40000000, MUL);
        drive(32'h0, 32'h0, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h7F800000) begin
            $display("FAIL mul_overflow: got %h expected %h", out, 32'h7F800000);
            failures++;
        end
        drive(32'h00000000, 32'hFF800000, MUL);
        drive(32'h0, 32'h0, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h7FC00000) begin
            $display("FAIL mul_zero_inf: got %h expected %h", out, 32'h7FC00000);
            failures++;
        end
    endtask

    task automatic test_back_to_back;
        drive(32'h3FC00000, 32'h40000000, MUL);
        drive(32'h3F800000, 32'h41200000, ADD);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h40400000) begin
            $display("FAIL collision_mul_wins: got %h expected %h", out, 32'h40400000);
            failures++;
        end
        drive(32'h0, 32'h0, RSV);
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h40400000) begin
            $display("FAIL collision_add_dropped: got %h expected %h", out, 32'h40400000);
            failures++;
        end
    endtask

    task automatic test_reset_midrun;
        drive(32'h3F800000, 32'h41200000, ADD);
        drive(32'h3FC00000, 32'h40000000, MUL);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 32'h00000000) begin
            $display("FAIL reset_async_clear: got %h expected %h", out, 32'h00000000);
            failures++;
        end
        drive(32'h0, 32'h0, RSV);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out !== 32'h00000000) begin
            $display("FAIL reset_mul_discarded: got %h expected %h", out, 32'h00000000);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
